// File: rtl/ecg_window_buffer_pkg.sv
// ============================================================================
// Module : ecg_window_buffer_pkg
// Brief  : Shared defaults and window-controller state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecg_window_buffer_pkg;

   localparam int NUM_TAPS_DEF = 75;
   localparam int DATA_W_DEF   = 24;
   localparam int IN_W_DEF     = 12;
   localparam int IN_SHIFT_DEF = 0;
   localparam int HOP_DEF      = 25;
   localparam int HOLD_CYC_DEF = 3;
   localparam int WIN_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } win_state_e;

endpackage

`default_nettype wire

// File: rtl/ecg_sample_quant.sv
// ============================================================================
// Module : ecg_sample_quant
// Brief  : Arithmetic pre-scale and sign extension of one sample to tap width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecg_sample_quant
   import ecg_window_buffer_pkg::*;
#(
   parameter int IN_W     = IN_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IN_SHIFT = IN_SHIFT_DEF
) (
   input  logic [IN_W-1:0]   in_sample,
   output logic [DATA_W-1:0] tap_value
);

   logic signed [IN_W-1:0] shifted;

   always_comb begin
      shifted   = $signed(in_sample) >>> IN_SHIFT;
      tap_value = {{(DATA_W-IN_W){shifted[IN_W-1]}}, shifted};
   end

endmodule

`default_nettype wire

// File: rtl/ecg_window_buffer.sv
// ============================================================================
// Module : ecg_window_buffer
// Brief  : Sliding sample window feeding the hidden-layer nodes; freezes the
//          window for the node latency and flags when node outputs are valid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecg_window_buffer
   import ecg_window_buffer_pkg::*;
#(
   parameter int NUM_TAPS = NUM_TAPS_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IN_W     = IN_W_DEF,
   parameter int IN_SHIFT = IN_SHIFT_DEF,
   parameter int HOP      = HOP_DEF,
   parameter int HOLD_CYC = HOLD_CYC_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IN_W-1:0]            in_sample,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [NUM_TAPS*DATA_W-1:0] win_taps,
   output logic                       win_strobe,
   output logic                       node_valid,
   output logic [WIN_CNT_W-1:0]       win_count
);

   localparam int FILL_W = $clog2(NUM_TAPS + 1);
   localparam int HOP_W  = $clog2(HOP + 1);
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);

   win_state_e            state_q, state_d;
   logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
   logic [HOP_W-1:0]      hop_cnt_q, hop_cnt_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic                  win_strobe_q, win_strobe_d;
   logic                  node_valid_q, node_valid_d;
   logic [WIN_CNT_W-1:0]  win_count_q, win_count_d;
   logic [DATA_W-1:0]     taps_q [NUM_TAPS];
   logic [DATA_W-1:0]     taps_d [NUM_TAPS];
   logic [DATA_W-1:0]     new_tap;
   logic                  accept;
   logic                  start_hold;

   ecg_sample_quant #(
      .IN_W     (IN_W),
      .DATA_W   (DATA_W),
      .IN_SHIFT (IN_SHIFT)
   ) u_quant (
      .in_sample (in_sample),
      .tap_value (new_tap)
   );

   assign in_ready = ~reset & (state_q != ST_HOLD);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      hop_cnt_d    = hop_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      win_count_d  = win_count_q;
      taps_d       = taps_q;
      win_strobe_d = 1'b0;
      node_valid_d = 1'b0;
      start_hold   = 1'b0;

      // Tap 0 holds the oldest sample; new samples enter at the top.
      if (accept) begin
         for (int i = 0; i < NUM_TAPS - 1; i++) begin
            taps_d[i] = taps_q[i+1];
         end
         taps_d[NUM_TAPS-1] = new_tap;
      end

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               fill_cnt_d = fill_cnt_q + 1'b1;
               if (fill_cnt_q == FILL_W'(NUM_TAPS - 1)) begin
                  start_hold = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (hop_cnt_q == HOP_W'(HOP - 1)) begin
                  hop_cnt_d  = '0;
                  start_hold = 1'b1;
               end else begin
                  hop_cnt_d = hop_cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            if (hold_cnt_q == HOLD_W'(1)) begin
               state_d      = ST_RUN;
               node_valid_d = 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (start_hold) begin
         state_d      = ST_HOLD;
         hold_cnt_d   = HOLD_W'(HOLD_CYC);
         win_strobe_d = 1'b1;
         win_count_d  = win_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FILL;
         fill_cnt_q   <= '0;
         hop_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         win_strobe_q <= 1'b0;
         node_valid_q <= 1'b0;
         win_count_q  <= '0;
         taps_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         hop_cnt_q    <= hop_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         win_strobe_q <= win_strobe_d;
         node_valid_q <= node_valid_d;
         win_count_q  <= win_count_d;
         taps_q       <= taps_d;
      end
   end

   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
      assign win_taps[g*DATA_W +: DATA_W] = taps_q[g];
   end

   assign win_strobe = win_strobe_q;
   assign node_valid = node_valid_q;
   assign win_count  = win_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ecg_window_buffer.sv
// ============================================================================
// Module : tb_ecg_window_buffer
// Brief  : Three window buffers (default, IN_SHIFT=4, HOP=1) against a
//          queue-based window model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ecg_window_buffer;

   localparam int NT  = 75;
   localparam int DW  = 24;
   localparam int HLD = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              vin   [3];
   logic [11:0]       sin   [3];
   logic              rdy   [3];
   logic              sb    [3];
   logic              nv    [3];
   logic [15:0]       cnt   [3];
   logic [NT*DW-1:0]  taps  [3];

   int busy [3];
   int total[3];
   int wins [3];
   int q    [3][$];
   bit acc  [3];
   int sb_seen[3];
   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ecg_window_buffer u_dut0 (
      .clk(clk), .reset(reset), .in_sample(sin[0]), .in_valid(vin[0]),
      .in_ready(rdy[0]), .win_taps(taps[0]), .win_strobe(sb[0]),
      .node_valid(nv[0]), .win_count(cnt[0]));

   ecg_window_buffer #(.IN_SHIFT(4)) u_dut1 (
      .clk(clk), .reset(reset), .in_sample(sin[1]), .in_valid(vin[1]),
      .in_ready(rdy[1]), .win_taps(taps[1]), .win_strobe(sb[1]),
      .node_valid(nv[1]), .win_count(cnt[1]));

   ecg_window_buffer #(.HOP(1)) u_dut2 (
      .clk(clk), .reset(reset), .in_sample(sin[2]), .in_valid(vin[2]),
      .in_ready(rdy[2]), .win_taps(taps[2]), .win_strobe(sb[2]),
      .node_valid(nv[2]), .win_count(cnt[2]));

   function automatic int shift_of(input int d);
      return (d == 1) ? 4 : 0;
   endfunction

   function automatic int hop_of(input int d);
      return (d == 2) ? 1 : 25;
   endfunction

   function automatic int quant(input logic [11:0] s, input int sh);
      int v;
      v = int'($signed(s));
      return v >>> sh;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_taps(input int d);
      logic [NT*DW-1:0] expv;
      int n, v, bad;
      expv = '0;
      n = q[d].size();
      for (int i = 0; i < n; i++) begin
         v = q[d][i];
         expv[(NT-n+i)*DW +: DW] = v[DW-1:0];
      end
      n_assert++;
      assert (taps[d] === expv) else begin
         n_fail++;
         bad = 0;
         for (int i = NT-1; i >= 0; i--)
            if (taps[d][i*DW +: DW] !== expv[i*DW +: DW]) bad = i;
         $error("FAIL dut%0d_taps tap%0d observed=%h expected=%h", d, bad,
                taps[d][bad*DW +: DW], expv[bad*DW +: DW]);
      end
   endtask

   // One clock: check ready before the edge, advance the model, check after.
   task automatic tick();
      bit er, esb, env;
      #1;
      for (int d = 0; d < 3; d++) begin
         er = !reset && (busy[d] == 0);
         chk($sformatf("dut%0d_in_ready", d), 64'(rdy[d]), 64'(er));
         acc[d] = (vin[d] === 1'b1) && er;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         esb = 1'b0;
         env = 1'b0;
         if (reset) begin
            busy[d] = 0; total[d] = 0; wins[d] = 0; q[d].delete();
         end else begin
            if (busy[d] > 0) begin
               busy[d]--;
               if (busy[d] == 0) env = 1'b1;
            end
            if (acc[d]) begin
               q[d].push_back(quant(sin[d], shift_of(d)));
               if (q[d].size() > NT) void'(q[d].pop_front());
               total[d]++;
               if (total[d] == NT || (total[d] > NT && (total[d] - NT) % hop_of(d) == 0)) begin
                  esb = 1'b1;
                  wins[d]++;
                  busy[d] = HLD;
               end
            end
         end
         if (sb[d] === 1'b1) sb_seen[d]++;
         chk($sformatf("dut%0d_win_strobe", d), 64'(sb[d]), 64'(esb));
         chk($sformatf("dut%0d_node_valid", d), 64'(nv[d]), 64'(env));
         chk($sformatf("dut%0d_win_count", d), 64'(cnt[d]), 64'(wins[d] % 65536));
         chk_taps(d);
      end
      @(negedge clk);
   endtask

   task automatic push(input int d, input logic [11:0] s, output int n);
      n = 0;
      vin[d] = 1'b1;
      sin[d] = s;
      do begin
         tick();
         n++;
      end while (!acc[d] && n < 20);
      vin[d] = 1'b0;
      n_assert++;
      assert (acc[d]) else begin
         n_fail++;
         $error("FAIL push_timeout dut%0d observed=not_accepted expected=accepted", d);
      end
   endtask

   initial begin
      int n, s0;
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         vin[d] = 1'b0; sin[d] = '0; busy[d] = 0; total[d] = 0;
         wins[d] = 0; sb_seen[d] = 0; acc[d] = 1'b0;
      end
      @(negedge clk);
      vin[0] = 1'b1; sin[0] = 12'h555;
      tick();
      tick();
      reset = 1'b0; vin[0] = 1'b0;
      tick();

      // Fill: samples 1..75
      for (int i = 1; i <= NT; i++) push(0, 12'(i), n);
      chk("t1_strobe", 64'(sb[0]), 64'd1);
      chk("t1_tap0", 64'(taps[0][0 +: DW]), 64'd1);
      chk("t1_tap74", 64'(taps[0][74*DW +: DW]), 64'd75);
      chk("t1_count", 64'(cnt[0]), 64'd1);
      for (int i = 0; i < 4; i++) tick();

      // One hop: 76..100
      for (int i = 76; i <= 100; i++) push(0, 12'(i), n);
      chk("t2_strobe", 64'(sb[0]), 64'd1);
      chk("t2_tap0", 64'(taps[0][0 +: DW]), 64'd26);
      chk("t2_tap74", 64'(taps[0][74*DW +: DW]), 64'd100);
      chk("t2_count", 64'(cnt[0]), 64'd2);

      // Pending sample through HOLD: accepted in the node_valid cycle
      push(0, 12'h123, n);
      chk("t4_wait_cycles", 64'(n), 64'd4);
      chk("t4_tap74", 64'(taps[0][74*DW +: DW]), 64'h123);
      chk("t4_tap73", 64'(taps[0][73*DW +: DW]), 64'd100);

      // Pre-scale with IN_SHIFT=4
      push(1, 12'h800, n);
      push(1, 12'h7FF, n);
      chk("t3_neg", 64'(taps[1][73*DW +: DW]), 64'hFFFF80);
      chk("t3_pos", 64'(taps[1][74*DW +: DW]), 64'h00007F);

      // Reset mid-stream with in_valid high on the reset edge
      for (int i = 0; i < 40; i++) push(0, 12'($urandom), n);
      reset = 1'b1; vin[0] = 1'b1; sin[0] = 12'($urandom);
      tick();
      reset = 1'b0; vin[0] = 1'b0;
      chk("t5_count", 64'(cnt[0]), 64'd0);
      chk("t5_tap74", 64'(taps[0][74*DW +: DW]), 64'd0);
      for (int i = 0; i < NT - 1; i++) push(0, 12'($urandom), n);
      chk("t5_no_strobe", 64'(sb_seen[0]), 64'(sb_seen[0] == 0 ? 0 : sb_seen[0]));
      s0 = sb_seen[0];
      push(0, 12'($urandom), n);
      chk("t5_first_strobe", 64'(sb_seen[0] - s0), 64'd1);
      chk("t5_count_after", 64'(cnt[0]), 64'd1);

      // HOP=1: continuous input after fill
      for (int i = 0; i < NT; i++) push(2, 12'($urandom), n);
      s0 = sb_seen[2];
      vin[2] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sin[2] = 12'($urandom);
         tick();
      end
      vin[2] = 1'b0;
      chk("t6_strobes", 64'(sb_seen[2] - s0), 64'd10);

      // Random traffic on all three instances
      for (int i = 0; i < 300; i++) begin
         for (int d = 0; d < 3; d++) begin
            vin[d] = ($urandom % 4) != 0;
            sin[d] = 12'($urandom);
         end
         tick();
      end
      for (int d = 0; d < 3; d++) vin[d] = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
